// File: rtl/pll_rst_seq.sv
// PLL reset sequencer and lock supervisor running on the 50 MHz reference clock.
// Optional retry limit with a latched FAIL state: define PLL_SEQ_RETRY_LIMIT_EN.
module pll_rst_seq #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int STABLE_CYC       = 1024,
  parameter int CNT_W            = 8,
  parameter int MAX_RETRY        = 4
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] retry_cnt,
  output logic             fail
);

  localparam int CYC_MAX_A = (LOCK_TIMEOUT_CYC > RST_PULSE_CYC) ? LOCK_TIMEOUT_CYC : RST_PULSE_CYC;
  localparam int CYC_MAX   = (STABLE_CYC > CYC_MAX_A) ? STABLE_CYC : CYC_MAX_A;
  localparam int CYC_W     = $clog2(CYC_MAX + 1);

  localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_PULSE_CYC - 1);
  localparam logic [CYC_W-1:0] TO_LAST  = CYC_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CYC_W-1:0] STB_LAST = CYC_W'(STABLE_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_TOP  = {CYC_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TOP  = {CNT_W{1'b1}};

  if (RST_PULSE_CYC < 2 || STABLE_CYC < 2 || LOCK_TIMEOUT_CYC < 1 ||
      CNT_W < 1 || MAX_RETRY < 1) begin : g_param_check
    $error("pll_rst_seq: illegal parameter value");
  end

  typedef enum logic [2:0] {
    ST_PRST   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
`else
    ST_RUN    = 3'd3
`endif
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CYC_W-1:0] cyc_r;
  logic             sync_r;
  logic             lk_r;
  logic             retry_inc_s;
  logic             loss_inc_s;
  logic [CNT_W-1:0] retry_cnt_r;
  logic [CNT_W-1:0] lock_loss_cnt_r;
  logic [CNT_W-1:0] retry_next_s;
  logic [CNT_W-1:0] loss_next_s;
  logic             pll_rst_s;
  logic             sys_rst_s;
  logic             ready_s;
  logic             pll_rst_r;
  logic             sys_rst_r;
  logic             ready_r;

  assign retry_next_s = (retry_cnt_r == CNT_TOP) ? CNT_TOP : retry_cnt_r + CNT_W'(1);
  assign loss_next_s  = (lock_loss_cnt_r == CNT_TOP) ? CNT_TOP : lock_loss_cnt_r + CNT_W'(1);

  // Two-flop synchronizer; lk_r is the only lock indication the FSM uses.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_r <= 1'b0;
      lk_r   <= 1'b0;
    end else begin
      sync_r <= pll_locked;
      lk_r   <= sync_r;
    end
  end

  // Next-state and counter-increment decisions.
  always_comb begin
    state_nxt_s = state_r;
    retry_inc_s = 1'b0;
    loss_inc_s  = 1'b0;
    case (state_r)
      ST_PRST: begin
        if (cyc_r == RST_LAST) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_PRST;
        end
      end
      ST_WAIT: begin
        if (lk_r) begin
          state_nxt_s = ST_STABLE;
        end else if (cyc_r == TO_LAST) begin
          retry_inc_s = 1'b1;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
          if (int'(retry_next_s) >= MAX_RETRY) begin
            state_nxt_s = ST_FAIL;
          end else begin
            state_nxt_s = ST_PRST;
          end
`else
          state_nxt_s = ST_PRST;
`endif
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_STABLE: begin
        if (!lk_r) begin
          state_nxt_s = ST_WAIT;
        end else if (cyc_r == STB_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_STABLE;
        end
      end
      ST_RUN: begin
        if (!lk_r) begin
          loss_inc_s  = 1'b1;
          state_nxt_s = ST_PRST;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      ST_FAIL: state_nxt_s = ST_FAIL;
`endif
      default: state_nxt_s = ST_PRST;
    endcase
  end

  // State register and the shared cycle counter, cleared on every transition.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_r <= ST_PRST;
      cyc_r   <= {CYC_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) begin
        cyc_r <= {CYC_W{1'b0}};
      end else if (cyc_r != CYC_TOP) begin
        cyc_r <= cyc_r + CYC_W'(1);
      end else begin
        cyc_r <= cyc_r;
      end
    end
  end

  // Saturating event counters.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      retry_cnt_r     <= {CNT_W{1'b0}};
      lock_loss_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (retry_inc_s) begin
        retry_cnt_r <= retry_next_s;
      end else begin
        retry_cnt_r <= retry_cnt_r;
      end
      if (loss_inc_s) begin
        lock_loss_cnt_r <= loss_next_s;
      end else begin
        lock_loss_cnt_r <= lock_loss_cnt_r;
      end
    end
  end

  // Output decode from the current state; registered below.
  always_comb begin
    pll_rst_s = 1'b1;
    sys_rst_s = 1'b1;
    ready_s   = 1'b0;
    case (state_r)
      ST_PRST:   pll_rst_s = 1'b1;
      ST_WAIT:   pll_rst_s = 1'b0;
      ST_STABLE: pll_rst_s = 1'b0;
      ST_RUN: begin
        pll_rst_s = 1'b0;
        sys_rst_s = 1'b0;
        ready_s   = 1'b1;
      end
      default:   pll_rst_s = 1'b1;
    endcase
  end

  // Output registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst_r <= 1'b1;
      sys_rst_r <= 1'b1;
      ready_r   <= 1'b0;
    end else begin
      pll_rst_r <= pll_rst_s;
      sys_rst_r <= sys_rst_s;
      ready_r   <= ready_s;
    end
  end

`ifdef PLL_SEQ_RETRY_LIMIT_EN
  logic fail_r;

  // Sticky failure flag, cleared only by rst.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      fail_r <= 1'b0;
    end else begin
      fail_r <= (state_r == ST_FAIL);
    end
  end

  assign fail = fail_r;
`else
  assign fail = 1'b0;
`endif

  assign pll_rst       = pll_rst_r;
  assign sys_rst       = sys_rst_r;
  assign ready         = ready_r;
  assign retry_cnt     = retry_cnt_r;
  assign lock_loss_cnt = lock_loss_cnt_r;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq: directed scenarios with literal expectations
// plus randomized lock/reset stimulus checked every cycle against a behavioural model.
module tb_pll_rst_seq;

  localparam int RP   = 4;
  localparam int TO   = 20;
  localparam int SC   = 8;
  localparam int CW   = 2;
  localparam int MR   = 3;
  localparam int CMAX = (1 << CW) - 1;

  localparam int PH_PULSE  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAIL   = 4;

  logic          refclk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          pll_rst;
  logic          sys_rst;
  logic          ready;
  logic          fail;
  logic [CW-1:0] lock_loss_cnt;
  logic [CW-1:0] retry_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  always #10 refclk = ~refclk;

  pll_rst_seq #(
    .RST_PULSE_CYC    (RP),
    .LOCK_TIMEOUT_CYC (TO),
    .STABLE_CYC       (SC),
    .CNT_W            (CW),
    .MAX_RETRY        (MR)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .pll_rst       (pll_rst),
    .sys_rst       (sys_rst),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt),
    .retry_cnt     (retry_cnt),
    .fail          (fail)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase, cycles spent in it, and lock samples delayed two edges.
  int m_ph, m_t, m_loss, m_retry;
  int n_ph, n_t, n_loss, n_retry;
  bit m_s1, m_lk;
  bit e_pll_rst, e_sys_rst, e_ready, e_fail;

  always_comb begin
    n_ph    = m_ph;
    n_t     = m_t + 1;
    n_loss  = m_loss;
    n_retry = m_retry;
    case (m_ph)
      PH_PULSE: begin
        if (m_t + 1 == RP) begin
          n_ph = PH_WAIT;
          n_t  = 0;
        end
      end
      PH_WAIT: begin
        if (m_lk) begin
          n_ph = PH_STABLE;
          n_t  = 0;
        end else if (m_t + 1 == TO) begin
          n_retry = (m_retry < CMAX) ? m_retry + 1 : CMAX;
          n_t     = 0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
          n_ph    = (n_retry >= MR) ? PH_FAIL : PH_PULSE;
`else
          n_ph    = PH_PULSE;
`endif
        end
      end
      PH_STABLE: begin
        if (!m_lk) begin
          n_ph = PH_WAIT;
          n_t  = 0;
        end else if (m_t + 1 == SC) begin
          n_ph = PH_RUN;
          n_t  = 0;
        end
      end
      PH_RUN: begin
        if (!m_lk) begin
          n_loss = (m_loss < CMAX) ? m_loss + 1 : CMAX;
          n_ph   = PH_PULSE;
          n_t    = 0;
        end
      end
      default: n_t = m_t;
    endcase
  end

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_ph <= PH_PULSE; m_t <= 0; m_loss <= 0; m_retry <= 0;
      m_s1 <= 1'b0; m_lk <= 1'b0;
      e_pll_rst <= 1'b1; e_sys_rst <= 1'b1; e_ready <= 1'b0; e_fail <= 1'b0;
    end else begin
      e_pll_rst <= (m_ph == PH_PULSE) || (m_ph == PH_FAIL);
      e_sys_rst <= (m_ph != PH_RUN);
      e_ready   <= (m_ph == PH_RUN);
      e_fail    <= (m_ph == PH_FAIL);
      m_ph <= n_ph; m_t <= n_t; m_loss <= n_loss; m_retry <= n_retry;
      m_s1 <= pll_locked;
      m_lk <= m_s1;
    end
  end

  always @(negedge refclk) begin
    if (cmp_en) begin
      chk("model pll_rst", int'(pll_rst), int'(e_pll_rst));
      chk("model sys_rst", int'(sys_rst), int'(e_sys_rst));
      chk("model ready", int'(ready), int'(e_ready));
      chk("model fail", int'(fail), int'(e_fail));
      chk("model lock_loss_cnt", int'(lock_loss_cnt), m_loss);
      chk("model retry_cnt", int'(retry_cnt), m_retry);
    end
  end

  // Edges after the first sampled edge until sys_rst reaches level; optional one-cycle glitch.
  task automatic wait_sys_rst(input logic level, input int glitch_at, output int d);
    d = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge refclk);
      @(negedge refclk);
      if (i == glitch_at) pll_locked = 1'b0;
      if (i == glitch_at + 1) pll_locked = 1'b1;
      if (sys_rst === level) begin
        d = i;
        break;
      end
    end
  endtask

  task automatic wait_ready(input string name);
    int ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge refclk);
      if (ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  initial begin
    int d, n, rises, last_rise;
    logic prev;
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    cmp_en = 1'b1;
    chk("reset pll_rst", int'(pll_rst), 1);
    chk("reset sys_rst", int'(sys_rst), 1);
    chk("reset ready", int'(ready), 0);
    chk("reset fail", int'(fail), 0);
    chk("reset lock_loss_cnt", int'(lock_loss_cnt), 0);
    chk("reset retry_cnt", int'(retry_cnt), 0);
    rst = 1'b0;

    // Scenario 1: power-up pulse width and lock latency.
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge refclk);
      @(negedge refclk);
      if (pll_rst === 1'b1) n++;
      else break;
    end
    chk("t1 pll_rst high edges", n, 4);
    repeat (4) @(negedge refclk);
    pll_locked = 1'b1;
    wait_sys_rst(1'b0, -10, d);
    chk("t1 lock latency", d, 11);
    chk("t1 ready", int'(ready), 1);
    chk("t1 lock_loss_cnt", int'(lock_loss_cnt), 0);
    chk("t1 retry_cnt", int'(retry_cnt), 0);

    // Scenario 3: one-cycle lock loss in RUN.
    pll_locked = 1'b0;
    wait_sys_rst(1'b1, -1, d);
    chk("t3 loss latency", d, 3);
    chk("t3 ready low", int'(ready), 0);
    chk("t3 lock_loss_cnt", int'(lock_loss_cnt), 1);
    wait_ready("t3 relock");

    // Scenario 4: glitch at stable count 6 restarts the window.
    pll_locked = 1'b0;
    repeat (12) @(negedge refclk);
    pll_locked = 1'b1;
    wait_sys_rst(1'b0, 6, d);
    chk("t4 glitched lock latency", d, 19);
    chk("t4 lock_loss_cnt", int'(lock_loss_cnt), 2);
    chk("t4 retry_cnt", int'(retry_cnt), 0);

    // Scenario 5: three more losses saturate the loss counter.
    for (int j = 0; j < 3; j++) begin
      pll_locked = 1'b0;
      wait_sys_rst(1'b1, -1, d);
      chk("t5 loss latency", d, 3);
      wait_ready("t5 relock");
    end
    chk("t5 lock_loss_cnt saturated", int'(lock_loss_cnt), 3);

    // Scenario 2: no lock, repeated timeouts.
    pll_locked = 1'b0;
    rises = 0;
    last_rise = 0;
    prev = pll_rst;
    for (int i = 0; i < 120; i++) begin
      @(posedge refclk);
      @(negedge refclk);
      if (pll_rst === 1'b1 && prev === 1'b0) begin
        if (rises == 0) chk("t2 first pulse", i, 3);
        else chk("t2 pulse period", i - last_rise, RP + TO);
        last_rise = i;
        rises++;
      end
      prev = pll_rst;
    end
    chk("t2 retry_cnt", int'(retry_cnt), 3);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    chk("t2 pulses before fail", rises, 4);
    chk("t2 fail", int'(fail), 1);
    chk("t2 pll_rst held", int'(pll_rst), 1);
`else
    chk("t2 pulses", rises, 5);
    chk("t2 fail tied low", int'(fail), 0);
    pll_locked = 1'b1;
    wait_ready("t6 reach run");
`endif

    // Scenario 6: asynchronous reset with counters nonzero.
    chk("t6 counters before reset", int'(lock_loss_cnt) + int'(retry_cnt), 6);
    #3 rst = 1'b1;
    #1;
    chk("t6 async sys_rst", int'(sys_rst), 1);
    chk("t6 async pll_rst", int'(pll_rst), 1);
    chk("t6 async ready", int'(ready), 0);
    chk("t6 async lock_loss_cnt", int'(lock_loss_cnt), 0);
    chk("t6 async retry_cnt", int'(retry_cnt), 0);
    chk("t6 async fail", int'(fail), 0);
    repeat (2) @(negedge refclk);
    rst = 1'b0;

    // Randomized lock behaviour with occasional asynchronous resets.
    for (int r = 0; r < 150; r++) begin
      pll_locked = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
      if (pll_locked) repeat ($urandom_range(1, 60)) @(negedge refclk);
      else repeat ($urandom_range(1, 32)) @(negedge refclk);
      if ($urandom_range(0, 19) == 0) begin
        #3 rst = 1'b1;
        @(negedge refclk);
        rst = 1'b0;
      end
    end

    repeat (3) @(negedge refclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
